// File: rtl/connect4_pkg.sv
// Shared Connect Four definitions: cell codes, board defaults, drop result codes
// and the piece_dropper state encoding.
package connect4_pkg;

    localparam int DEF_ROWS = 6;
    localparam int DEF_COLS = 7;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] RES_PLACED  = 2'b00;
    localparam logic [1:0] RES_FULL    = 2'b01;
    localparam logic [1:0] RES_INVALID = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WRITE,
        ST_START_CHECK,
        ST_WAIT_CLR,
        ST_WAIT_CHECK,
        ST_DONE
    } drop_state_t;

endpackage

// File: rtl/piece_dropper.sv
// Column-drop engine: scans a column bottom-up, writes the piece into the first
// empty cell, runs the victory checker on it and reports placed/full/invalid.
module piece_dropper
    import connect4_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       drop_valid,
    output logic       drop_ready,
    input  logic [2:0] drop_col,
    input  logic [1:0] drop_player,
    output logic       rd_sel,
    output logic [2:0] row_read,
    output logic [2:0] col_read,
    input  logic [1:0] data_in,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic [2:0] move_row,
    output logic [2:0] move_col,
    output logic       check_start,
    input  logic       check_done,
    output logic       done,
    output logic [1:0] result
);

    localparam logic [2:0] TOP_ROW = 3'(ROWS - 1);

    drop_state_t state;
    logic [2:0]  row_q;
    logic [2:0]  col_q;
    logic [1:0]  player_q;
    logic        req_bad;

    assign req_bad = ({1'b0, drop_col} >= 4'(COLS)) ||
                     (drop_player != CELL_P1 && drop_player != CELL_P2);

    // The read and write addresses are the same registered row/column pair;
    // rd_sel and wr_en qualify which use is live.
    assign row_read = row_q;
    assign col_read = col_q;
    assign wr_row   = row_q;
    assign wr_col   = col_q;
    assign wr_data  = player_q;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            drop_ready  <= 1'b1;
            rd_sel      <= 1'b0;
            wr_en       <= 1'b0;
            check_start <= 1'b0;
            done        <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            player_q    <= '0;
            move_row    <= '0;
            move_col    <= '0;
            result      <= RES_PLACED;
        end else begin
            wr_en       <= 1'b0;
            check_start <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (drop_valid) begin
                        col_q      <= drop_col;
                        player_q   <= drop_player;
                        drop_ready <= 1'b0;
                        if (req_bad) begin
                            result <= RES_INVALID;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            result <= RES_PLACED;
                            row_q  <= '0;
                            rd_sel <= 1'b1;
                            state  <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (data_in == CELL_EMPTY) begin
                        rd_sel   <= 1'b0;
                        wr_en    <= 1'b1;
                        move_row <= row_q;
                        move_col <= col_q;
                        state    <= ST_WRITE;
                    end else if (row_q == TOP_ROW) begin
                        rd_sel <= 1'b0;
                        result <= RES_FULL;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        row_q <= row_q + 3'd1;
                    end
                end
                ST_WRITE: begin
                    check_start <= 1'b1;
                    state       <= ST_START_CHECK;
                end
                ST_START_CHECK: state <= ST_WAIT_CLR;
                // check_done may still be high from the previous move here.
                ST_WAIT_CLR:    state <= ST_WAIT_CHECK;
                ST_WAIT_CHECK: begin
                    if (check_done) begin
                        result <= RES_PLACED;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    drop_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    drop_ready <= 1'b1;
                    rd_sel     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_dropper.sv
// Self-checking bench for piece_dropper: board storage and victory-checker models,
// directed scenarios plus randomized drops against a column-fill reference model.
module tb_piece_dropper;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    logic       clk;
    logic       rst_n;
    logic       drop_valid;
    logic       drop_ready;
    logic [2:0] drop_col;
    logic [1:0] drop_player;
    logic       rd_sel;
    logic [2:0] row_read, col_read;
    logic [1:0] data_in;
    logic       wr_en;
    logic [2:0] wr_row, wr_col;
    logic [1:0] wr_data;
    logic [2:0] move_row, move_col;
    logic       check_start;
    logic       check_done;
    logic       done;
    logic [1:0] result;

    piece_dropper #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n),
        .drop_valid(drop_valid), .drop_ready(drop_ready),
        .drop_col(drop_col), .drop_player(drop_player),
        .rd_sel(rd_sel), .row_read(row_read), .col_read(col_read), .data_in(data_in),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .move_row(move_row), .move_col(move_col),
        .check_start(check_start), .check_done(check_done),
        .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board storage driven by the DUT's write port; exp_board is the bench's own view.
    logic [1:0] board     [ROWS][COLS];
    logic [1:0] exp_board [ROWS][COLS];
    logic       clr_req;

    always @(posedge clk) begin
        if (clr_req) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= 2'b00;
        end else if (wr_en && wr_row < ROWS && wr_col < COLS) begin
            board[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        data_in = 2'b00;
        if (row_read < ROWS && col_read < COLS)
            data_in = board[row_read][col_read];
    end

    // Victory checker model: done level stays high one cycle past start, then drops
    // and re-rises after chk_lat cycles.
    int  chk_lat;
    int  chk_cnt;
    logic clr_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_done <= 1'b0;
            clr_pend   <= 1'b0;
            chk_cnt    <= 0;
        end else if (check_start) begin
            clr_pend <= 1'b1;
        end else if (clr_pend) begin
            clr_pend   <= 1'b0;
            check_done <= 1'b0;
            chk_cnt    <= chk_lat;
        end else if (chk_cnt > 0) begin
            chk_cnt <= chk_cnt - 1;
            if (chk_cnt == 1) check_done <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {27'd0, drop_ready, rd_sel, wr_en, check_start, done}, 32'b10000);
        check({tag, "_rdaddr"}, {26'd0, row_read, col_read}, 0);
        check({tag, "_wr"}, {24'd0, wr_row, wr_col, wr_data}, 0);
        check({tag, "_move_res"}, {24'd0, move_row, move_col, result}, 0);
    endtask

    task automatic clear_board();
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_board[r][c] = 2'b00;
    endtask

    task automatic compare_board(input string tag);
        int bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (board[r][c] !== exp_board[r][c]) bad++;
        check(tag, bad, 0);
    endtask

    // Lowest empty row of a column in the bench's board, -1 if the column is full.
    function automatic int first_empty(input int col);
        for (int r = 0; r < ROWS; r++)
            if (exp_board[r][col] == 2'b00) return r;
        return -1;
    endfunction

    // One drop request; all timing is measured in cycles after the acceptance cycle.
    task automatic do_drop(input int col, input logic [1:0] pl, input int lat, input bit hold);
        int exp_res, exp_r, exp_wr, exp_cs, exp_done, exp_rd;
        int wr_cnt = 0, cs_cnt = 0, rd_cnt = 0, addr_bad = 0, busy_ready = 0;
        int wr_at = -1, cs_at = -1, done_at = -1;
        logic [7:0] wr_seen = '0;
        logic [5:0] move_seen = '0;
        logic [1:0] res_seen = 2'b11;

        exp_r = -1;
        if (col >= COLS || !(pl == 2'b01 || pl == 2'b10)) begin
            exp_res = 2; exp_done = 1; exp_rd = 0; exp_wr = -1; exp_cs = -1;
        end else begin
            exp_r = first_empty(col);
            if (exp_r < 0) begin
                exp_res = 1; exp_done = ROWS + 1; exp_rd = ROWS; exp_wr = -1; exp_cs = -1;
            end else begin
                exp_res  = 0;
                exp_wr   = exp_r + 2;
                exp_cs   = exp_r + 3;
                exp_done = exp_r + 6 + lat;
                exp_rd   = exp_r + 1;
                exp_board[exp_r][col] = pl;
            end
        end

        chk_lat = lat;
        @(negedge clk);
        check("ready_idle", drop_ready, 1);
        drop_valid  = 1'b1;
        drop_col    = 3'(col);
        drop_player = pl;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!hold || !rd_sel) drop_valid = 1'b0;
            if (drop_ready) busy_ready++;
            if (rd_sel) begin
                if (row_read != 3'(rd_cnt) || col_read != 3'(col)) addr_bad++;
                rd_cnt++;
            end
            if (wr_en) begin
                wr_cnt++; wr_at = n; wr_seen = {wr_row, wr_col, wr_data};
            end
            if (check_start) begin
                cs_cnt++; cs_at = n; move_seen = {move_row, move_col};
            end
            if (done) begin
                done_at = n; res_seen = result;
                break;
            end
        end
        drop_valid = 1'b0;

        check("result", res_seen, exp_res);
        check("done_at", done_at, exp_done);
        check("busy_ready", busy_ready, 0);
        check("scan_reads", rd_cnt, exp_rd);
        check("scan_addr", addr_bad, 0);
        check("wr_count", wr_cnt, exp_wr < 0 ? 0 : 1);
        check("cs_count", cs_cnt, exp_cs < 0 ? 0 : 1);
        if (exp_wr >= 0) begin
            check("wr_at", wr_at, exp_wr);
            check("wr_data", wr_seen, {3'(exp_r), 3'(col), pl});
            check("cs_at", cs_at, exp_cs);
            check("move", move_seen, {3'(exp_r), 3'(col)});
        end
    endtask

    initial begin
        int r4, rcol, rpl;

        rst_n       = 1'b0;
        drop_valid  = 1'b0;
        drop_col    = '0;
        drop_player = '0;
        clr_req     = 1'b0;
        chk_lat     = 1;
        clear_board();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Empty board, fastest checker.
        do_drop(3, 2'b01, 1, 1'b0);

        // Stack column 2 with three pieces, the fourth lands on row 3.
        do_drop(2, 2'b01, 2, 1'b0);
        do_drop(2, 2'b10, 3, 1'b0);
        do_drop(2, 2'b01, 1, 1'b0);
        do_drop(2, 2'b10, 4, 1'b0);
        check("move_row_hold", move_row, 3);

        // Fill column 5, then the seventh drop reports full.
        for (int i = 0; i < ROWS; i++) do_drop(5, (i % 2) ? 2'b10 : 2'b01, 1, 1'b0);
        do_drop(5, 2'b01, 1, 1'b0);

        // Invalid column and invalid player code.
        do_drop(7, 2'b01, 1, 1'b0);
        do_drop(1, 2'b11, 1, 1'b0);
        do_drop(1, 2'b00, 1, 1'b0);

        // check_done is still high from the last placement; slow fresh done.
        do_drop(3, 2'b10, 16, 1'b0);

        // Reset asserted while waiting on the victory checker.
        r4 = first_empty(4);
        if (r4 >= 0) exp_board[r4][4] = 2'b01;
        chk_lat = 16;
        @(negedge clk);
        drop_valid = 1'b1; drop_col = 3'd4; drop_player = 2'b01;
        @(negedge clk);
        drop_valid = 1'b0;
        for (int n = 0; n < 20 && !check_start; n++) @(negedge clk);
        check("rst_cs_seen", check_start, 1);
        repeat (3) @(negedge clk);
        check("rst_pre_done", done, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Normal drop after reset, with drop_valid held through the scan.
        do_drop(0, 2'b10, 2, 1'b1);
        compare_board("board_directed");

        clear_board();
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                compare_board("board_rand_a");
                clear_board();
            end
            rcol = $urandom_range(0, 7);
            rpl  = $urandom_range(0, 9);
            do_drop(rcol, rpl < 4 ? 2'b01 : rpl < 8 ? 2'b10 : rpl == 8 ? 2'b00 : 2'b11,
                    $urandom_range(1, 20), 1'($urandom_range(0, 1)));
        end
        compare_board("board_rand_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
